// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
package pll_seq_pkg;

    // Sequencer states; the numeric codes are visible on state_dbg.
    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    // Smallest width w such that 2**w >= value, never less than 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((longint'(1) << i) < longint'(value)) begin
                result = i + 1;
            end
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

    // Largest of three cycle counts, used to size the shared counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) begin
            m = b;
        end
        if (c > m) begin
            m = c;
        end
        return m;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser bringing an asynchronous level into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // First flop may go metastable; second flop gives it a full cycle to settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_seq.sv
// Power-up and recovery sequencer for the board PLL: pulses PLL reset, waits
// for lock with a timeout, qualifies lock as stable, then releases sys_rst.
// Repeated lock timeouts latch a fault until relock_req.
module pll_reset_seq
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES   = 50,
    parameter int LOCK_TIMEOUT = 50000,
    parameter int LOCK_STABLE  = 1024,
    parameter int MAX_RETRY    = 3
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic       relock_req,
    output logic       pll_reset,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic       lock_lost,
    output logic [1:0] retry_cnt,
    output logic [2:0] state_dbg
);

    localparam int CNT_W = clog2(max3(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE) + 1);

    // Terminal counts: the counter starts at 0 on state entry, so the last
    // cycle of an N-cycle window is count N-1.
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRY);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       retry_nxt;
    logic             lost_nxt;
    logic             lock_s;

    sync_2ff u_lock_sync (
        .clk (clkin),
        .rst (reset),
        .d   (pll_lock),
        .q   (lock_s)
    );

    assign state_dbg = state;

    // Next-state, retry and lock-loss decisions; relock_req overrides everything.
    always_comb begin
        state_nxt = state;
        retry_nxt = retry_cnt;
        lost_nxt  = 1'b0;

        if (relock_req) begin
            state_nxt = S_RESET;
            retry_nxt = '0;
        end else begin
            case (state)
                S_RESET: begin
                    if (cnt == RST_LAST) begin
                        state_nxt = S_WAIT_LOCK;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_nxt = S_STABLE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        if (retry_cnt == RETRY_MAX) begin
                            state_nxt = S_FAULT;
                        end else begin
                            state_nxt = S_RESET;
                            retry_nxt = retry_cnt + 2'd1;
                        end
                    end
                end
                S_STABLE: begin
                    if (!lock_s) begin
                        state_nxt = S_WAIT_LOCK;
                    end else if (cnt == STABLE_LAST) begin
                        state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        state_nxt = S_RESET;
                        lost_nxt  = 1'b1;
                    end
                end
                S_FAULT: begin
                    state_nxt = S_FAULT;
                end
                default: begin
                    state_nxt = S_RESET;
                end
            endcase
        end

        if (state_nxt == S_RUN) begin
            retry_nxt = '0;
        end
    end

    // Shared cycle counter: cleared on any transition or relock, otherwise
    // advances only in the states that time something.
    always_comb begin
        cnt_nxt = cnt;
        if (relock_req || (state_nxt != state)) begin
            cnt_nxt = '0;
        end else if ((state == S_RESET) || (state == S_WAIT_LOCK) || (state == S_STABLE)) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    // State, counter and registered outputs; outputs decode the next state so
    // they change on the same edge as the state itself.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state     <= S_RESET;
            cnt       <= '0;
            retry_cnt <= '0;
            pll_reset <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            fault     <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            retry_cnt <= retry_nxt;
            pll_reset <= (state_nxt == S_RESET) || (state_nxt == S_FAULT);
            sys_rst   <= (state_nxt != S_RUN);
            ready     <= (state_nxt == S_RUN);
            fault     <= (state_nxt == S_FAULT);
            lock_lost <= lost_nxt;
        end
    end

endmodule
